// File: rtl/demux_pkg.sv
// Shared constants and types for the two-lane demux buffer.
// Holds the default widths/depth and the derived FIFO pointer width.
package demux_pkg;

  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 5;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef logic lane_t;

endpackage

// File: rtl/demux_buffer_2lane_fifo_sync_lane.sv
// Single-clock lane FIFO with explicit occupancy count; full at DEPTH, empty at 0.
// The head word is forced to zero while the FIFO is empty.
module fifo_sync_lane #(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int DEPTH  = demux_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  import demux_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full lane never accepts, even if a same-cycle pop would free a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/demux_buffer_2lane.sv
// Routes the mux word stream into two lane FIFOs chosen by selector.
// Per-lane accepted-word counters exist only when DEMUX_COUNT_EN is defined.
module demux_buffer_2lane #(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int DEPTH  = demux_pkg::DEPTH,
  parameter int CNT_W  = demux_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              selector,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  input  logic              ready_out0,
  input  logic              ready_out1,
  output logic [CNT_W-1:0]  contador0,
  output logic [CNT_W-1:0]  contador1
);
  import demux_pkg::*;

  lane_t sel_lane;
  logic  full0, full1, empty0, empty1;
  logic  push_acc, push0, push1;

  assign sel_lane = selector;

  // ready_in only looks at the addressed lane's registered full flag.
  assign ready_in = (sel_lane == 1'b1) ? !full1 : !full0;
  assign push_acc = valid_in && ready_in;
  assign push0    = push_acc && (sel_lane == 1'b0);
  assign push1    = push_acc && (sel_lane == 1'b1);

  assign valid_out0 = !empty0;
  assign valid_out1 = !empty1;

  fifo_sync_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk     (clk),
    .reset   (reset),
    .push    (push0),
    .pop     (ready_out0),
    .wr_data (data_in),
    .rd_data (data_out0),
    .full    (full0),
    .empty   (empty0)
  );

  fifo_sync_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk     (clk),
    .reset   (reset),
    .push    (push1),
    .pop     (ready_out1),
    .wr_data (data_in),
    .rd_data (data_out1),
    .full    (full1),
    .empty   (empty1)
  );

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (push0) cnt0_d = cnt0_q + 1'b1;
    if (push1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign contador0 = cnt0_q;
  assign contador1 = cnt1_q;
`else
  assign contador0 = '0;
  assign contador1 = '0;
`endif

endmodule

// File: tb/tb_demux_buffer_2lane.sv
// Randomized and directed bench for demux_buffer_2lane against a queue-based lane model.
// Counter expectations follow DEMUX_COUNT_EN when it is defined for the build.
module tb_demux_buffer_2lane;
   import demux_pkg::*;

   logic clk = 1'b0;
   logic reset, valid_in, selector, ready_out0, ready_out1;
   logic [DATA_W-1:0] data_in, data_out0, data_out1;
   logic ready_in, valid_out0, valid_out1;
   logic [CNT_W-1:0] contador0, contador1;

   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   int cnt0Model = 0;
   int cnt1Model = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   demux_buffer_2lane dut (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (valid_in),
      .selector   (selector),
      .data_in    (data_in),
      .ready_in   (ready_in),
      .valid_out0 (valid_out0),
      .valid_out1 (valid_out1),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .ready_out0 (ready_out0),
      .ready_out1 (ready_out1),
      .contador0  (contador0),
      .contador1  (contador1)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int expCount(input int c);
`ifdef DEMUX_COUNT_EN
      return c;
`else
      return 0 * c;
`endif
   endfunction

   // Compares every DUT output with what the lane queues say it should be.
   task automatic checkModel();
      int occ;
      occ = selector ? q1.size() : q0.size();
      checkOutput("ready_in", 32'(ready_in), 32'(occ < DEPTH));
      checkOutput("valid_out0", 32'(valid_out0), 32'(q0.size() != 0));
      checkOutput("valid_out1", 32'(valid_out1), 32'(q1.size() != 0));
      checkOutput("data_out0", 32'(data_out0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
      checkOutput("data_out1", 32'(data_out1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
      checkOutput("contador0", 32'(contador0), 32'(expCount(cnt0Model)));
      checkOutput("contador1", 32'(contador1), 32'(expCount(cnt1Model)));
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model past the edge.
   task automatic applyStimulus(input logic rst, input logic vin, input logic sel,
                                input logic [DATA_W-1:0] din, input logic r0, input logic r1);
      logic doPush, doPop0, doPop1;
      reset = rst; valid_in = vin; selector = sel; data_in = din;
      ready_out0 = r0; ready_out1 = r1;
      #1;
      checkModel();
      doPush = vin && ((sel ? q1.size() : q0.size()) < DEPTH);
      doPop0 = r0 && (q0.size() != 0);
      doPop1 = r1 && (q1.size() != 0);
      @(posedge clk);
      if (rst) begin
         q0.delete(); q1.delete();
         cnt0Model = 0; cnt1Model = 0;
      end else begin
         if (doPop0) void'(q0.pop_front());
         if (doPop1) void'(q1.pop_front());
         if (doPush && !sel) begin q0.push_back(din); cnt0Model = (cnt0Model + 1) % (1 << CNT_W); end
         if (doPush && sel)  begin q1.push_back(din); cnt1Model = (cnt1Model + 1) % (1 << CNT_W); end
      end
      #1;
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; selector = 1'b0; data_in = '0;
      ready_out0 = 1'b0; ready_out1 = 1'b0;
      @(posedge clk); @(posedge clk); #1;

      // Reset then idle, looking at ready_in for both selector values.
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("idle_ready_sel1", 32'(ready_in), 32'd1);

      // One word into each lane, consumers always ready.
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
      checkOutput("lane1_word", 32'(data_out1), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

      // Fill lane 0, try a fifth push, then drain in order.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, DATA_W'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("full_other_lane_ready", 32'(ready_in), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
      checkOutput("full_no_bypass", 32'(valid_out0), 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         reset = 1'b0; valid_in = 1'b0; ready_out0 = 1'b1; #1;
         checkOutput("drain_order", 32'(data_out0), 32'(i));
         applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      end

      // Occupancy 2 with simultaneous push and pop.
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
      checkOutput("pushpop_head", 32'(data_out0), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
      checkOutput("pushpop_last", 32'(data_out0), 32'd3);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

      // Three words per lane, then reset with a push pending.
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, i[0], DATA_W'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("post_reset_valid0", 32'(valid_out0), 32'd0);
      checkOutput("post_reset_cnt0", 32'(contador0), 32'd0);

      // 33 pushes to lane 1 exercise the counter wrap.
      for (int i = 0; i < 33; i++) applyStimulus(1'b0, 1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
`ifdef DEMUX_COUNT_EN
      checkOutput("cnt1_wrap", 32'(contador1), 32'd1);
`else
      checkOutput("cnt1_disabled", 32'(contador1), 32'd0);
`endif

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                       DATA_W'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
